// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the FFT output path
package fft_pkg;

    localparam int FFT_DATA_W = 9;
    localparam int FFT_N      = 8;
    localparam int FFT_IDX_W  = 3;

    localparam logic [FFT_IDX_W-1:0] FFT_LAST_IDX = FFT_IDX_W'(FFT_N - 1);

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_PRIME  = 2'd1,
        SER_STREAM = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fft_out_serializer_if.sv
// rtl/fft_out_serializer_if.sv - bin stream with valid/ready, last and index tags
interface fft_out_serializer_if;
    import fft_pkg::*;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [FFT_DATA_W-1:0] out_re;
    logic signed [FFT_DATA_W-1:0] out_im;
    logic [FFT_IDX_W-1:0]         out_idx;
    logic                         out_last;

    modport master (
        output out_valid,
        output out_re,
        output out_im,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/fft_mag_l1.sv
// rtl/fft_mag_l1.sv - combinational |re|+|im| of a signed complex sample
module fft_mag_l1 #(
    parameter int DATA_W = 9
) (
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    output logic [DATA_W:0]          o_mag
);

    logic [DATA_W:0] w_re_ext;
    logic [DATA_W:0] w_im_ext;
    logic [DATA_W:0] w_re_abs;
    logic [DATA_W:0] w_im_abs;

    // One extra bit makes the most negative input's magnitude representable.
    assign w_re_ext = {i_re[DATA_W-1], i_re};
    assign w_im_ext = {i_im[DATA_W-1], i_im};
    assign w_re_abs = i_re[DATA_W-1] ? (~w_re_ext + 1'b1) : w_re_ext;
    assign w_im_abs = i_im[DATA_W-1] ? (~w_im_ext + 1'b1) : w_im_ext;
    assign o_mag    = w_re_abs + w_im_abs;

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - sweeps core bins, streams them in order and tracks the L1 peak
module fft_out_serializer
    import fft_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [FFT_IDX_W-1:0]         sel,
    input  logic signed [FFT_DATA_W-1:0] yr,
    input  logic signed [FFT_DATA_W-1:0] yi,
    fft_out_serializer_if.master         out_if,
    output logic                         busy,
    output logic                         done,
    output logic [FFT_IDX_W-1:0]         peak_idx,
    output logic [FFT_DATA_W:0]          peak_mag
);

    ser_state_t           r_state;
    ser_state_t           w_state_nxt;
    logic [FFT_IDX_W-1:0] r_idx;
    logic [FFT_IDX_W-1:0] r_max_idx;
    logic [FFT_DATA_W:0]  r_max_mag;
    logic [FFT_IDX_W-1:0] r_peak_idx;
    logic [FFT_DATA_W:0]  r_peak_mag;
    logic                 r_done;
    logic [FFT_DATA_W:0]  w_mag;
    logic                 w_valid;
    logic                 w_hs;
    logic                 w_last_hs;
    logic                 w_new_max;
    logic                 w_frame_open;

    fft_mag_l1 #(
        .DATA_W (FFT_DATA_W)
    ) u_mag (
        .i_re  (yr),
        .i_im  (yi),
        .o_mag (w_mag)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_valid      = 1'b0;
        w_hs         = 1'b0;
        w_last_hs    = 1'b0;
        w_frame_open = 1'b0;
        sel          = '0;
        case (r_state)
            SER_IDLE: begin
                if (start) begin
                    w_state_nxt  = SER_PRIME;
                    w_frame_open = 1'b1;
                end
            end
            SER_PRIME: begin
                w_state_nxt = SER_STREAM;
            end
            SER_STREAM: begin
                w_valid   = 1'b1;
                w_hs      = out_if.out_ready;
                w_last_hs = out_if.out_ready && (r_idx == FFT_LAST_IDX);
                // Look ahead by one bin on a handshake so the core's registered
                // output already holds the next bin on the following beat.
                sel       = r_idx + {{(FFT_IDX_W-1){1'b0}}, out_if.out_ready};
                if (w_last_hs) begin
                    w_state_nxt = SER_IDLE;
                end
            end
            default: begin
                w_state_nxt = SER_IDLE;
            end
        endcase
    end

    assign w_new_max = (w_mag > r_max_mag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= SER_IDLE;
            r_idx      <= '0;
            r_max_idx  <= '0;
            r_max_mag  <= '0;
            r_peak_idx <= '0;
            r_peak_mag <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_hs;
            if (w_frame_open) begin
                r_idx     <= '0;
                r_max_idx <= '0;
                r_max_mag <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + 1'b1;
                if (w_new_max) begin
                    r_max_idx <= r_idx;
                    r_max_mag <= w_mag;
                end
            end
            // The final beat's magnitude is folded in directly since the
            // running max only catches up on the same edge.
            if (w_last_hs) begin
                r_peak_idx <= w_new_max ? r_idx : r_max_idx;
                r_peak_mag <= w_new_max ? w_mag : r_max_mag;
            end
        end
    end

    assign out_if.out_valid = w_valid;
    assign out_if.out_re    = yr;
    assign out_if.out_im    = yi;
    assign out_if.out_idx   = r_idx;
    assign out_if.out_last  = w_valid && (r_idx == FFT_LAST_IDX);

    assign busy     = (r_state == SER_PRIME) || (r_state == SER_STREAM);
    assign done     = r_done;
    assign peak_idx = r_peak_idx;
    assign peak_mag = r_peak_mag;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - randomized and directed self-checking bench for fft_out_serializer
module tb_fft_out_serializer;
    import fft_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         start;
    logic [FFT_IDX_W-1:0]         sel;
    logic signed [FFT_DATA_W-1:0] yr;
    logic signed [FFT_DATA_W-1:0] yi;
    logic                         busy;
    logic                         done;
    logic [FFT_IDX_W-1:0]         peak_idx;
    logic [FFT_DATA_W:0]          peak_mag;

    fft_out_serializer_if u_if ();

    fft_out_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sel      (sel),
        .yr       (yr),
        .yi       (yi),
        .out_if   (u_if),
        .busy     (busy),
        .done     (done),
        .peak_idx (peak_idx),
        .peak_mag (peak_mag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int core_mode = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Mode 0: ramp; mode 1: one strong bin at 4; mode 2: equal strong bins at 4 and 6.
    function automatic int core_re(input int s);
        case (core_mode)
            0:       return 3 * s - 10;
            1:       return (s == 4) ? -256 : 0;
            default: return (s == 4 || s == 6) ? -256 : 0;
        endcase
    endfunction

    function automatic int core_im(input int s);
        case (core_mode)
            0:       return s;
            1:       return (s == 4) ? 0 : 255;
            default: return (s == 4 || s == 6) ? 0 : 255;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin
        yr <= FFT_DATA_W'(core_re(int'(sel)));
        yi <= FFT_DATA_W'(core_im(int'(sel)));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic ref_peak(output int pi, output int pm);
        pi = 0;
        pm = 0;
        for (int b = 0; b < FFT_N; b++) begin
            int m;
            m = iabs(core_re(b)) + iabs(core_im(b));
            if (m > pm) begin
                pm = m;
                pi = b;
            end
        end
    endtask

    bit m_prime = 1'b0;
    bit m_stream = 1'b0;
    bit m_done = 1'b0;
    int m_bin = 0;
    int m_pidx = 0;
    int m_pmag = 0;

    int st_vcnt;
    int st_dcnt;
    int st_first;
    int st_done_cyc;
    int st_re[$];
    int st_im[$];
    int st_idx[$];

    always @(negedge clk) begin
        if (chk_en) begin
            bit hs;
            chk("out_valid", int'(u_if.out_valid), int'(m_stream));
            chk("busy", int'(busy), int'(m_prime | m_stream));
            chk("done", int'(done), int'(m_done));
            chk("peak_idx", int'(peak_idx), m_pidx);
            chk("peak_mag", int'(peak_mag), m_pmag);
            chk("out_last", int'(u_if.out_last), int'(m_stream && m_bin == FFT_N - 1));
            if (m_stream) begin
                chk("out_idx", int'(u_if.out_idx), m_bin);
                chk("out_re", int'($signed(u_if.out_re)), core_re(m_bin));
                chk("out_im", int'($signed(u_if.out_im)), core_im(m_bin));
                chk("sel_stream", int'(sel), (m_bin + int'(u_if.out_ready)) % FFT_N);
            end else begin
                chk("sel_idle", int'(sel), 0);
            end

            hs = m_stream && u_if.out_ready;
            if (m_stream) begin
                if (st_vcnt == 0) st_first = cyc_n;
                st_vcnt++;
            end
            if (hs) begin
                st_re.push_back(int'($signed(u_if.out_re)));
                st_im.push_back(int'($signed(u_if.out_im)));
                st_idx.push_back(int'(u_if.out_idx));
            end
            if (done) begin
                st_dcnt++;
                st_done_cyc = cyc_n;
            end

            if (!rst_n) begin
                m_prime  = 1'b0;
                m_stream = 1'b0;
                m_done   = 1'b0;
                m_bin    = 0;
                m_pidx   = 0;
                m_pmag   = 0;
            end else begin
                m_done = hs && (m_bin == FFT_N - 1);
                if (m_prime) begin
                    m_prime  = 1'b0;
                    m_stream = 1'b1;
                    m_bin    = 0;
                end else if (hs) begin
                    if (m_bin == FFT_N - 1) begin
                        m_stream = 1'b0;
                        ref_peak(m_pidx, m_pmag);
                    end else begin
                        m_bin++;
                    end
                end else if (!m_stream && start) begin
                    m_prime = 1'b1;
                end
            end
        end
    end

    int t0;

    // rm: 0 ready high, 1 stall 3 at idx 2, 2 alternate, 3 random, 4 start at idx 3, 5 reset at idx 5
    task automatic run_frame(input int rm, input int pct);
        int  k;
        int  stall;
        int  after;
        bit  trig;
        bit  rst_did;
        stall   = 0;
        after   = 0;
        trig    = 1'b0;
        rst_did = 1'b0;
        st_vcnt = 0;
        st_dcnt = 0;
        st_first = -1;
        st_done_cyc = -1;
        st_re.delete();
        st_im.delete();
        st_idx.delete();
        t0 = cyc_n;
        start = 1'b1;
        u_if.out_ready = (rm == 2) ? 1'b0 : 1'b1;
        for (k = 1; k < 200; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst_n = 1'b1;
            if (rm == 5 && rst_did) begin
                after++;
                if (after > 12) break;
                continue;
            end
            if (st_dcnt > 0 && !busy) break;
            case (rm)
                1: begin
                    if (u_if.out_valid && u_if.out_idx == 3'd2 && stall < 3) begin
                        u_if.out_ready = 1'b0;
                        stall++;
                    end else begin
                        u_if.out_ready = 1'b1;
                    end
                end
                2: u_if.out_ready = k[0];
                3: begin
                    u_if.out_ready = ($urandom_range(99) < pct);
                    start = u_if.out_valid && ($urandom_range(7) == 0);
                end
                4: begin
                    u_if.out_ready = 1'b1;
                    if (u_if.out_valid && u_if.out_idx == 3'd3 && !trig) begin
                        start = 1'b1;
                        trig  = 1'b1;
                    end
                end
                5: begin
                    u_if.out_ready = 1'b1;
                    if (u_if.out_valid && u_if.out_idx == 3'd5) begin
                        rst_n   = 1'b0;
                        rst_did = 1'b1;
                    end
                end
                default: u_if.out_ready = 1'b1;
            endcase
        end
        n_cmp++;
        if (k >= 200) begin
            n_err++;
            $display("FAIL frame_timeout: no done within %0d cycles (mode %0d)", k, rm);
        end
        start = 1'b0;
        u_if.out_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_beats_in_order();
        chk("beat_count", st_idx.size(), FFT_N);
        if (st_idx.size() == FFT_N) begin
            for (int i = 0; i < FFT_N; i++) chk("beat_idx_seq", st_idx[i], i);
        end
    endtask

    int exp_re[FFT_N] = '{-10, -7, -4, -1, 2, 5, 8, 11};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        u_if.out_ready = 1'b0;
        core_mode = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Basic frame with literal expectations
        run_frame(0, 100);
        chk_beats_in_order();
        if (st_re.size() == FFT_N) begin
            for (int i = 0; i < FFT_N; i++) begin
                chk("lit_re", st_re[i], exp_re[i]);
                chk("lit_im", st_im[i], i);
            end
        end
        chk("first_beat_latency", st_first - t0, 2);
        chk("done_latency", st_done_cyc - t0, 10);
        chk("done_count", st_dcnt, 1);
        chk("lit_peak_idx", int'(peak_idx), 7);
        chk("lit_peak_mag", int'(peak_mag), 18);
        idle(2);

        run_frame(1, 100);
        chk_beats_in_order();
        chk("stall_valid_cycles", st_vcnt, 11);
        idle(2);

        run_frame(2, 100);
        chk_beats_in_order();
        chk("alt_valid_cycles", st_vcnt, 16);
        chk("alt_done_latency", st_done_cyc - t0, 18);
        idle(2);

        core_mode = 1;
        run_frame(0, 100);
        chk("lit_peak_idx_m1", int'(peak_idx), 4);
        chk("lit_peak_mag_m1", int'(peak_mag), 256);
        idle(2);

        core_mode = 2;
        run_frame(0, 100);
        chk("lit_peak_idx_tie", int'(peak_idx), 4);
        chk("lit_peak_mag_tie", int'(peak_mag), 256);
        idle(2);

        core_mode = 0;
        run_frame(4, 100);
        chk_beats_in_order();
        chk("start_ignored_done", st_dcnt, 1);
        idle(4);
        chk("start_ignored_busy", int'(busy), 0);

        run_frame(5, 100);
        chk("reset_no_done", st_dcnt, 0);
        chk("reset_peak_mag", int'(peak_mag), 0);
        chk("reset_peak_idx", int'(peak_idx), 0);
        run_frame(0, 100);
        chk_beats_in_order();
        chk("post_reset_done", st_dcnt, 1);
        idle(2);

        for (int f = 0; f < 25; f++) begin
            core_mode = int'($urandom_range(2));
            run_frame(3, int'($urandom_range(90, 30)));
            chk_beats_in_order();
            idle(int'($urandom_range(3)));
        end

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Downstream stage of the 8-point DIT FFT core. On `start`, it sweeps the core's 3-bit `sel` bin selector and compensates for the core's one-cycle registered output. It then streams the eight complex bins in natural order over a valid/ready interface with last/index tags. While streaming, it tracks the peak L1-magnitude bin of the frame and reports it with a `done` pulse.

## Interface
- `DATA_W`, 9: width of core `yr`/`yi`, two's complement.
- `N`, 8: FFT points per frame (power of 2).
- `IDX_W`, 3: log2(N); width of `sel` and `out_idx`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to stream the current frame; honoured only in IDLE.
- `sel`  out  IDX_W  bin select to core.
- `yr`  in  DATA_W  core real output, valid one cycle after `sel`.
- `yi`  in  DATA_W  core imaginary output, valid one cycle after `sel`.
- `out_valid`  out  1  bin beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `out_re`  out  DATA_W  bin real part (= `yr`).
- `out_im`  out  DATA_W  bin imaginary part (= `yi`).
- `out_idx`  out  IDX_W  bin number of the current beat.
- `out_last`  out  1  high on bin N-1 beat.
- `busy`  out  1  high in PRIME/STREAM.
- `done`  out  1  one-cycle pulse after the final handshake.
- `peak_idx`  out  IDX_W  index of largest |re|+|im| in the last frame.
- `peak_mag`  out  DATA_W+1  that magnitude, unsigned.

## Operation
- FSM states:
  - IDLE: `start` moves to PRIME.
  - PRIME: unconditionally moves to STREAM.
  - STREAM: handshake on bin N-1 moves to IDLE.
- Handshake: `hs = out_valid & out_ready`.
- `idx` register:
  - cleared on PRIME entry.
  - increments on `hs`.
  - wraps N-1→0.
  - `out_idx = idx`.
- `sel` per state:
  - IDLE and PRIME: `sel = 0`.
  - STREAM: `sel = idx + hs`, mod N.
- The `sel` mux is combinational from `out_ready`. This is intentional: the core register then holds bin `idx` while stalled, and advances to `idx+1` exactly at the beat after a handshake.
- Stream outputs:
  - `out_valid` is high only in STREAM.
  - `out_re`/`out_im` are direct pass-through of `yr`/`yi`.
  - `out_last = (idx == N-1) & out_valid`.
- Peak tracking:
  - Magnitude: `mag = |yr| + |yi|`, DATA_W+1 bits, unsigned.
  - |−2^(DATA_W−1)| = 2^(DATA_W−1); no saturation is needed.
  - Running max is reset to 0 and index 0 on PRIME entry.
  - The running max updates on `hs` when `mag > max`, strictly greater, so ties keep the lowest index.
  - `peak_idx`/`peak_mag` are registered. They load from the running max on the final handshake and hold until the next frame's final handshake.
- `start` while `busy` is ignored: no restart, no error.
- `out_valid` may not be withdrawn once asserted until `hs`. `out_re`/`out_im`/`out_idx` are stable while stalled.

## Timing
- Reset (`rst_n` low at a rising edge) forces, regardless of state, including mid-frame:
  - state IDLE, `idx` 0, running max 0.
  - `sel` 0, `out_valid` 0, `out_last` 0, `busy` 0, `done` 0.
  - `peak_idx` 0, `peak_mag` 0.
- No partial-frame `done` is produced after reset.
- Latency: `start` at cycle T gives PRIME at T+1 (`sel`=0) and first beat (bin 0) at T+2.
- With `out_ready` held high, beats run T+2…T+9, `out_last` at T+9, and `done` plus updated peak at T+10.
- Throughput is one bin per cycle when not stalled.
- `done` is high the cycle after the last `hs`, with state already IDLE. A `start` in that same cycle is accepted.
- `busy` is high from T+1 through the final-handshake cycle.

## Structure
- Shared package `fft_pkg`:
  - `FFT_DATA_W`=9, `FFT_N`=8, `FFT_IDX_W`=3.
  - the serializer state enum (IDLE/PRIME/STREAM).
- One sub-module `fft_mag_l1`: combinational `|re|+|im|` for a complex DATA_W sample, output DATA_W+1 bits. The same sub-module is reusable for later magnitude stages.
- The bench must use a core model that registers `yr`/`yi` from `sel` with one-cycle latency. The model returns `yr = 3*sel − 10`, `yi = sel` (9-bit two's complement).

## Test plan
- Reset, then `start` with `out_ready`=1 → beats at T+2…T+9 with `out_idx` 0..7, `out_re` −10,−7,−4,−1,2,5,8,11, `out_im` 0..7; `out_last` at idx 7; `done` at T+10; `peak_idx`=7, `peak_mag`=18.
- Deassert `out_ready` for 3 cycles at idx 2 → `out_valid` stays high; `out_re`=−4 and `out_idx`=2 held; `sel`=2 while stalled; stream resumes with idx 3 and no bin skipped or duplicated.
- Alternate `out_ready` every cycle → 8 beats in 16 cycles, all values correct; `done` one cycle after the idx-7 handshake.
- Core model with `yr`=−256, `yi`=0 on bin 4 and `yr`=0, `yi`=255 elsewhere → `peak_mag`=256, `peak_idx`=4. A tie with 256 also at bin 6 still gives `peak_idx`=4.
- `start` pulsed during STREAM at idx 3 → ignored; a single frame of 8 beats and a single `done`.
- `rst_n` low at idx 5 → next cycle all outputs are at reset values; no `done`; `peak_*` is 0. A new `start` then gives a clean full frame from idx 0.
